// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with HI/LO result registers (MIPS-style).
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle product.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     cnt;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     rs_q;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0_q;
  logic                 is_mul, is_div, is_signed, last;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic                 sa, sb;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic use_sign);
    return (use_sign && v < 0) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = is_signed & rs_data[WIDTH-1];
  assign sb        = is_signed & rt_data[WIDTH-1];
  assign last      = (cnt == WIDTH'(WIDTH - 1));
  assign busy      = (state != IDLE);

  // One shift-add step: add the multiplicand into the upper half when the multiplier LSB is set.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  // One restoring step: a borrow out (MSB set) means the divisor did not fit.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = FIX;
`else
          state_nxt = MUL;
`endif
        end else if (start && is_div) begin
          state_nxt = DIV;
        end
      end
      MUL:     if (last) state_nxt = FIX;
      DIV:     if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if ((state == MUL) || (state == DIV))
        cnt <= last ? '0 : cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Operand capture and iteration datapath; no reset needed since FIX is the only consumer.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start && (is_mul || is_div)) begin
      op_q   <= op;
      rs_q   <= rs_data;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      div0_q <= (rt_data == '0);
      if (is_mul) begin
        opnd <= abs_val(rs_data, is_signed);
`ifdef MULDIV_FAST_MUL_EN
        acc  <= {{WIDTH{1'b0}}, abs_val(rs_data, is_signed)} *
                {{WIDTH{1'b0}}, abs_val(rt_data, is_signed)};
`else
        acc  <= {{WIDTH{1'b0}}, abs_val(rt_data, is_signed)};
`endif
      end else begin
        opnd <= abs_val(rt_data, is_signed);
        acc  <= {{WIDTH{1'b0}}, abs_val(rs_data, is_signed)};
      end
    end else if (state == MUL) begin
      acc <= {mul_sum, acc[WIDTH-1:1]};
    end else if (state == DIV) begin
      if (div_trial[WIDTH])
        acc <= {acc[2*WIDTH-2:0], 1'b0};
      else
        acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
        {hi, lo} <= neg_q ? (2*WIDTH)'(-acc) : acc;
      end else if (div0_q) begin
        hi <= rs_q;
        lo <= '1;
      end else begin
        lo <= apply_sign(acc[WIDTH-1:0], neg_q);
        hi <= apply_sign(acc[2*WIDTH-1:WIDTH], neg_r);
      end
    end else if ((state == IDLE) && start) begin
      if (op == OP_MTHI) hi <= rs_data;
      if (op == OP_MTLO) lo <= rs_data;
    end
  end

endmodule
